bus_slave_param: RTL and testbench

BUS_SLAVE_PARAM -- requirements
Module: bus_slave_param

---
 rtl/bus_slave_param_if.sv | 28 ++
 rtl/bus_slave_param.sv | 214 +++++++++++++++++++++
 tb/tb_bus_slave_param.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_param_if.sv
// Serial request/response bus between a master and bus_slave_param.
interface bus_slave_param_if;
  logic read_en;
  logic write_en;
  logic master_valid;
  logic master_ready;
  logic rx_address;
  logic rx_data;
  logic rx_burst;
  logic slave_ready;
  logic slave_valid;
  logic tx_data;
  logic rx_done;
  logic slave_tx_done;
  logic error;

  modport slave (
    input  read_en, write_en, master_valid, master_ready,
    input  rx_address, rx_data, rx_burst,
    output slave_ready, slave_valid, tx_data, rx_done, slave_tx_done, error
  );

  modport master (
    output read_en, write_en, master_valid, master_ready,
    output rx_address, rx_data, rx_burst,
    input  slave_ready, slave_valid, tx_data, rx_done, slave_tx_done, error
  );
endinterface

// File: rtl/bus_slave_param.sv
// Bit-serial memory slave: serial address/burst/data in, serial read data out,
// backed by an internal synchronous single-port word memory.
module bus_slave_param #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 4096,
  parameter int BURST_WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  bus_slave_param_if.slave bus
);

  localparam int MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W  = $clog2(MAX_W + 1);
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [CNT_W-1:0]      ADDR_LAST  = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]      DATA_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      BURST_BITS = CNT_W'(BURST_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X    = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP   = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX_ADDR   = 3'd1,
    RX_DATA   = 3'd2,
    WR_COMMIT = 3'd3,
    RD_FETCH  = 3'd4,
    RD_LOAD   = 3'd5,
    TX        = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic                    mode_wr_q, mode_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BURST_WIDTH-1:0]  burst_q, burst_d;
  logic [BURST_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
  logic                    rx_done_q, rx_done_d;
  logic                    tx_done_q, tx_done_d;
  logic                    error_q, error_d;

  logic                    ready_st;
  logic                    xfer;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   addr_shift;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [MEM_AW-1:0]       mem_idx;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  // Burst address advance wraps at the top of the implemented memory, not at 2**ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_TOP) ? '0 : a + 1'b1;
  endfunction

  function automatic logic addr_out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} >= DEPTH_X;
  endfunction

  assign ready_st   = (state_q == IDLE) || (state_q == RX_ADDR) || (state_q == RX_DATA);
  assign xfer       = bus.master_valid && ready_st;
  assign addr_shift = (addr_q << 1) | ADDR_WIDTH'(bus.rx_address);

  always_comb begin
    state_d   = state_q;
    mode_wr_d = mode_wr_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    tx_sh_d   = tx_sh_q;
    rx_done_d = 1'b0;
    tx_done_d = 1'b0;
    error_d   = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer && (bus.read_en ^ bus.write_en)) begin
          mode_wr_d = bus.write_en;
          addr_d    = '0;
          burst_d   = '0;
          beat_d    = '0;
          cnt_d     = '0;
          state_d   = RX_ADDR;
        end
      end

      RX_ADDR: begin
        if (xfer) begin
          addr_d = addr_shift;
          if (cnt_q < BURST_BITS) begin
            burst_d = (burst_q << 1) | BURST_WIDTH'(bus.rx_burst);
          end
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            if (addr_out_of_range(addr_shift)) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = mode_wr_q ? RX_DATA : RD_FETCH;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (xfer) begin
          wdata_d = (wdata_q << 1) | DATA_WIDTH'(bus.rx_data);
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = WR_COMMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      WR_COMMIT: begin
        mem_we = 1'b1;
        if (beat_q != burst_q) begin
          beat_d  = beat_q + 1'b1;
          addr_d  = next_addr(addr_q);
          state_d = RX_DATA;
        end else begin
          rx_done_d = 1'b1;
          state_d   = IDLE;
        end
      end

      // addr_q is already on the memory read port; the word lands in rd_data_q next cycle.
      RD_FETCH: state_d = RD_LOAD;

      RD_LOAD: begin
        tx_sh_d = rd_data_q;
        cnt_d   = '0;
        state_d = TX;
      end

      TX: begin
        if (bus.master_ready) begin
          tx_sh_d = tx_sh_q << 1;
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (beat_q != burst_q) begin
              beat_d  = beat_q + 1'b1;
              addr_d  = next_addr(addr_q);
              state_d = RD_FETCH;
            end else begin
              tx_done_d = 1'b1;
              state_d   = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mode_wr_q <= 1'b0;
      addr_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      tx_sh_q   <= '0;
      rx_done_q <= 1'b0;
      tx_done_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_wr_q <= mode_wr_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      tx_sh_q   <= tx_sh_d;
      rx_done_q <= rx_done_d;
      tx_done_q <= tx_done_d;
      error_q   <= error_d;
    end
  end

  // Memory contents survive reset; only in-range addresses ever reach the port.
  assign mem_idx = addr_q[MEM_AW-1:0];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
    rd_data_q <= mem[mem_idx];
  end

  assign bus.slave_ready   = reset && ready_st;
  assign bus.slave_valid   = (state_q == TX);
  assign bus.tx_data       = (state_q == TX) ? tx_sh_q[DATA_WIDTH-1] : 1'b0;
  assign bus.rx_done       = rx_done_q;
  assign bus.slave_tx_done = tx_done_q;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_bus_slave_param.sv
// Directed bench for bus_slave_param: a full-depth and a half-depth instance,
// checked every cycle against a transaction-level expectation plus literal checks.
module tb_bus_slave_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_slave_param_if bus_a ();
  bus_slave_param_if bus_b ();

  logic sel;
  logic drv_re, drv_we, drv_mv, drv_mr, drv_addr, drv_data, drv_burst;

  assign bus_a.read_en      = !sel && drv_re;
  assign bus_a.write_en     = !sel && drv_we;
  assign bus_a.master_valid = !sel && drv_mv;
  assign bus_a.master_ready = !sel && drv_mr;
  assign bus_a.rx_address   = !sel && drv_addr;
  assign bus_a.rx_data      = !sel && drv_data;
  assign bus_a.rx_burst     = !sel && drv_burst;
  assign bus_b.read_en      = sel && drv_re;
  assign bus_b.write_en     = sel && drv_we;
  assign bus_b.master_valid = sel && drv_mv;
  assign bus_b.master_ready = sel && drv_mr;
  assign bus_b.rx_address   = sel && drv_addr;
  assign bus_b.rx_data      = sel && drv_data;
  assign bus_b.rx_burst     = sel && drv_burst;

  bus_slave_param #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(4096), .BURST_WIDTH(2))
    dut_a (.clk(clk), .reset(rst_n), .bus(bus_a));
  bus_slave_param #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(2048), .BURST_WIDTH(2))
    dut_b (.clk(clk), .reset(rst_n), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_cyc  = 0;
  int last_rxd_cyc = 0;
  int rxd_cnt_a = 0;
  int err_cnt_b = 0;
  logic       chk_en = 1'b0;
  logic [5:0] exp_v  = '0;   // {ready, valid, tx_data, rx_done, tx_done, error}
  logic [7:0] ref_a [4096];
  logic [7:0] ref_b [2048];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(input int i);
    case (i)
      0: return "error";
      1: return "slave_tx_done";
      2: return "rx_done";
      3: return "tx_data";
      4: return "slave_valid";
      default: return "slave_ready";
    endcase
  endfunction

  task automatic chk_vec(input string who, input logic [5:0] got, input logic [5:0] want);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL cyc=%0d %s.%s got=%b want=%b", cyc, who, sig_name(i), got[i], want[i]);
      end
    end
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  function automatic logic [5:0] idle_v();
    return rst_n ? 6'b100000 : 6'b000000;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk_vec("dut_a", {bus_a.slave_ready, bus_a.slave_valid, bus_a.tx_data,
                        bus_a.rx_done, bus_a.slave_tx_done, bus_a.error},
              sel ? idle_v() : exp_v);
      chk_vec("dut_b", {bus_b.slave_ready, bus_b.slave_valid, bus_b.tx_data,
                        bus_b.rx_done, bus_b.slave_tx_done, bus_b.error},
              sel ? exp_v : idle_v());
    end
    if (bus_a.rx_done) begin
      rxd_cnt_a++;
      last_rxd_cyc = cyc;
    end
    if (bus_b.error) err_cnt_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic r, input logic v, input logic t,
                            input logic rd, input logic td, input logic e);
    exp_v = {r, v, t, rd, td, e};
  endtask

  task automatic drive_zero();
    drv_re = 0; drv_we = 0; drv_mv = 0; drv_mr = 0;
    drv_addr = 0; drv_data = 0; drv_burst = 0;
  endtask

  task automatic idle(input int n);
    drive_zero();
    for (int k = 0; k < n; k++) begin
      expect_out(1, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  function automatic int depth_of();
    return sel ? 2048 : 4096;
  endfunction

  function automatic logic [11:0] wrap_inc(input logic [11:0] a);
    return (int'(a) == depth_of() - 1) ? 12'd0 : a + 12'd1;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [11:0] a);
    return sel ? ref_b[a[10:0]] : ref_a[a];
  endfunction

  task automatic ref_wr(input logic [11:0] a, input logic [7:0] d);
    if (sel) ref_b[a[10:0]] = d;
    else     ref_a[a] = d;
  endtask

  function automatic logic sel_tx();
    return sel ? bus_b.tx_data : bus_a.tx_data;
  endfunction

  // Handshake plus ADDR_WIDTH address bits; the enables are flipped afterwards
  // because the slave must ignore them once the mode is latched.
  task automatic send_hdr(input logic wr, input logic [11:0] addr, input logic [1:0] bl);
    drv_we = wr; drv_re = !wr; drv_mv = 1'b1;
    expect_out(1, 0, 0, 0, 0, 0);
    hs_cyc = cyc;
    tick();
    drv_we = !wr; drv_re = wr;
    for (int i = 0; i < 12; i++) begin
      drv_addr  = addr[11-i];
      drv_burst = 1'b0;
      if (i == 0) drv_burst = bl[1];
      if (i == 1) drv_burst = bl[0];
      expect_out(1, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic write_txn(input logic [11:0] addr, input logic [1:0] bl,
                           input logic [31:0] words, input int abort_bit);
    logic [11:0] a;
    logic [7:0]  d;
    send_hdr(1'b1, addr, bl);
    if (int'(addr) >= depth_of()) begin
      drive_zero();
      expect_out(1, 0, 0, 0, 0, 1);
      tick();
      return;
    end
    a = addr;
    for (int b = 0; b <= int'(bl); b++) begin
      d = words[31-8*b -: 8];
      for (int i = 0; i < 8; i++) begin
        drv_data = d[7-i];
        if (b == 0 && i == abort_bit) begin
          rst_n = 1'b0;
          drive_zero();
          expect_out(0, 0, 0, 0, 0, 0);
          tick();
          tick();
          rst_n = 1'b1;
          return;
        end
        expect_out(1, 0, 0, 0, 0, 0);
        tick();
      end
      expect_out(0, 0, 0, 0, 0, 0);
      ref_wr(a, d);
      a = wrap_inc(a);
      tick();
    end
    drive_zero();
    expect_out(1, 0, 0, 1, 0, 0);
    tick();
  endtask

  task automatic read_txn(input logic [11:0] addr, input logic [1:0] bl,
                          input logic toggle, output logic [31:0] got);
    logic [11:0] a;
    logic [7:0]  d;
    int i;
    int t;
    send_hdr(1'b0, addr, bl);
    drv_mv = 1'b0;
    a = addr;
    got = '0;
    for (int b = 0; b <= int'(bl); b++) begin
      drv_mr = 1'b0;
      expect_out(0, 0, 0, 0, 0, 0);
      tick();
      expect_out(0, 0, 0, 0, 0, 0);
      tick();
      d = ref_rd(a);
      i = 0;
      t = 0;
      while (i < 8) begin
        drv_mr = toggle ? (t % 2 == 0) : 1'b1;
        expect_out(0, 1, d[7-i], 0, 0, 0);
        if (drv_mr) begin
          got = {got[30:0], sel_tx()};
          i++;
        end
        tick();
        t++;
      end
      a = wrap_inc(a);
    end
    drive_zero();
    expect_out(1, 0, 0, 0, 1, 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int n0;
    for (int k = 0; k < 4096; k++) ref_a[k] = 8'h00;
    for (int k = 0; k < 2048; k++) ref_b[k] = 8'h00;
    sel = 1'b0;
    drive_zero();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    expect_out(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    idle(2);

    write_txn(12'h005, 2'd0, 32'hA500_0000, -1);
    check_lit("rx_done_latency", last_rxd_cyc - hs_cyc, 22);
    idle(2);
    read_txn(12'h005, 2'd0, 1'b0, got);
    check_lit("read_005", int'(got), 32'h0000_00A5);
    idle(2);

    n0 = rxd_cnt_a;
    write_txn(12'hFFE, 2'd3, 32'h1122_3344, -1);
    check_lit("burst_rx_done_count", rxd_cnt_a - n0, 1);
    idle(2);
    read_txn(12'hFFE, 2'd3, 1'b0, got);
    check_lit("burst_read_ffe", int'(got), 32'h1122_3344);
    read_txn(12'hFFF, 2'd1, 1'b0, got);
    check_lit("read_wrap_fff", int'(got), 32'h0000_2233);
    idle(1);

    read_txn(12'h005, 2'd0, 1'b1, got);
    check_lit("read_005_stall", int'(got), 32'h0000_00A5);
    idle(2);

    write_txn(12'h7FF, 2'd1, 32'h00FF_0000, -1);
    idle(1);
    read_txn(12'h7FF, 2'd1, 1'b1, got);
    check_lit("read_7ff_pair", int'(got), 32'h0000_00FF);
    idle(2);

    write_txn(12'h010, 2'd0, 32'h3C00_0000, -1);
    idle(2);
    write_txn(12'h010, 2'd0, 32'hFF00_0000, 3);
    idle(2);
    read_txn(12'h010, 2'd0, 1'b0, got);
    check_lit("abort_keeps_010", int'(got), 32'h0000_003C);
    idle(2);

    sel = 1'b1;
    idle(2);
    write_txn(12'h000, 2'd0, 32'h5A00_0000, -1);
    idle(1);
    n0 = err_cnt_b;
    write_txn(12'h800, 2'd0, 32'hFF00_0000, -1);
    check_lit("error_pulse_count", err_cnt_b - n0, 1);
    idle(2);
    read_txn(12'h000, 2'd0, 1'b0, got);
    check_lit("no_write_on_error", int'(got), 32'h0000_005A);
    idle(1);

    drv_re = 1'b1; drv_we = 1'b1; drv_mv = 1'b1; drv_addr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      expect_out(1, 0, 0, 0, 0, 0);
      tick();
    end
    idle(2);
    check_lit("both_enables_no_error", err_cnt_b - n0, 1);
    read_txn(12'h000, 2'd0, 1'b1, got);
    check_lit("read_after_both", int'(got), 32'h0000_005A);
    sel = 1'b0;
    idle(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
